pad_input_sync_filter: RTL and testbench

//  Consumes the raw pad_out_o values of the input pad cells: a bank of NPADS asynchronous pad inputs.
//  Per pad: synchronizes into clk_i, deglitches with a programmable stability counter, emits rise/fall pulses.

---
 rtl/pad_filter_pkg.sv | 13 +
 rtl/pad_input_sync_filter_if.sv | 24 ++
 rtl/pad_input_filter_ch.sv | 57 +++++
 rtl/pad_input_sync_filter.sv | 38 +++
 tb/tb_pad_input_sync_filter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pad_filter_pkg.sv
// Shared types and defaults for the pad input synchronizer/deglitch filter.
package pad_filter_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

  typedef logic [CNT_W_DEF-1:0] filt_cnt_t;

  typedef struct packed {
    logic      level;
    filt_cnt_t cnt;
  } pad_filter_state_t;
endpackage

// File: rtl/pad_input_sync_filter_if.sv
// Pad bank bus: raw pad values and filter controls in, filtered level and edge pulses out.
interface pad_input_sync_filter_if
  import pad_filter_pkg::*;
#(
  parameter int NPADS = 8,
  parameter int CNT_W = CNT_W_DEF
);
  logic [NPADS-1:0] pad_in_i;
  logic [NPADS-1:0] filter_en_i;
  logic [CNT_W-1:0] filter_len_i;
  logic [NPADS-1:0] level_o;
  logic [NPADS-1:0] rise_o;
  logic [NPADS-1:0] fall_o;

  modport master (
    output pad_in_i, filter_en_i, filter_len_i,
    input  level_o, rise_o, fall_o
  );

  modport slave (
    input  pad_in_i, filter_en_i, filter_len_i,
    output level_o, rise_o, fall_o
  );
endinterface

// File: rtl/pad_input_filter_ch.sv
// One pad channel: synchronizer chain, stability counter, registered level and edge pulses.
module pad_input_filter_ch #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pad_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);
  // r_sync[0] is the only flop sampling the async pad: CDC metastability stage.
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic w_s;
  logic w_diff;
  logic w_bypass;
  logic w_due;
  logic w_upd;
  logic w_hold;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_s ^ r_level;
  assign w_bypass = ~en_i | (len_i == '0);
  // >= lets a shortened length commit at once; len_i=0 is covered by bypass.
  assign w_due    = r_cnt >= (len_i - CNT_W'(1));
  assign w_upd    = w_diff & (w_bypass | w_due);
  assign w_hold   = w_diff & ~w_bypass & ~w_due;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync  <= {SYNC_STAGES{RESET_VAL}};
      r_level <= RESET_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pad_i};
      r_level <= w_upd ? w_s : r_level;
      r_cnt   <= w_hold ? r_cnt + CNT_W'(1) : '0;
      r_rise  <= w_upd & w_s;
      r_fall  <= w_upd & ~w_s;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
endmodule

// File: rtl/pad_input_sync_filter.sv
// Bank of NPADS independent pad channels sharing one filter length.
module pad_input_sync_filter
  import pad_filter_pkg::*;
#(
  parameter int               NPADS       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [NPADS-1:0] RESET_VAL   = '0
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  pad_input_sync_filter_if.slave bus
);
  logic [NPADS-1:0] w_level;
  logic [NPADS-1:0] w_rise;
  logic [NPADS-1:0] w_fall;

  for (genvar g = 0; g < NPADS; g++) begin : g_ch
    pad_input_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL[g])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .pad_i   (bus.pad_in_i[g]),
      .en_i    (bus.filter_en_i[g]),
      .len_i   (bus.filter_len_i),
      .level_o (w_level[g]),
      .rise_o  (w_rise[g]),
      .fall_o  (w_fall[g])
    );
  end

  assign bus.level_o = w_level;
  assign bus.rise_o  = w_rise;
  assign bus.fall_o  = w_fall;
endmodule

// File: tb/tb_pad_input_sync_filter.sv
// Self-checking bench for pad_input_sync_filter: directed table, corner sequences, scoreboard.
module tb_pad_input_sync_filter;
  localparam int NP = 8;
  localparam int SS = 2;
  localparam int CW = 8;
  localparam logic [NP-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pad_input_sync_filter_if #(.NPADS(NP), .CNT_W(CW)) bus ();

  pad_input_sync_filter #(
    .NPADS(NP), .SYNC_STAGES(SS), .CNT_W(CW), .RESET_VAL(RV)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0] lvl;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
  } obs_t;

  typedef struct {
    logic [NP-1:0] pad;
    logic [NP-1:0] en;
    logic [CW-1:0] len;
    int            ncyc;
    logic [NP-1:0] lvl;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
  } vec_t;

  obs_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Spec-level reference: two sync stages, level, counter and pulses per pad.
  logic [NP-1:0] m_s0, m_s1, m_lvl, m_rise, m_fall;
  int m_cnt[NP];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NP-1:0] s;
    logic upd;
    s = m_s1;
    if (!rst_n) begin
      m_s0 = RV; m_s1 = RV; m_lvl = RV; m_rise = '0; m_fall = '0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        upd = 1'b0;
        if (!bus.filter_en_i[p] || bus.filter_len_i == 0) begin
          upd = (s[p] != m_lvl[p]);
          m_cnt[p] = 0;
        end else if (s[p] == m_lvl[p]) begin
          m_cnt[p] = 0;
        end else if (m_cnt[p] >= int'(bus.filter_len_i) - 1) begin
          upd = 1'b1;
          m_cnt[p] = 0;
        end else begin
          m_cnt[p] = m_cnt[p] + 1;
        end
        m_rise[p] = upd & s[p];
        m_fall[p] = upd & ~s[p];
        if (upd) m_lvl[p] = s[p];
      end
      m_s1 = m_s0;
      m_s0 = bus.pad_in_i;
    end
  endtask

  task automatic cyc();
    obs_t e;
    model_edge();
    e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check("sb_level", bus.level_o, e.lvl);
      check("sb_rise", bus.rise_o, e.rise);
      check("sb_fall", bus.fall_o, e.fall);
      check("sb_both", bus.rise_o & bus.fall_o, 32'd0);
    end
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic obs(input string nm, input logic [NP-1:0] l,
                     input logic [NP-1:0] r, input logic [NP-1:0] f);
    check({nm, "_level"}, bus.level_o, l);
    check({nm, "_rise"}, bus.rise_o, r);
    check({nm, "_fall"}, bus.fall_o, f);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{8'h00, 8'h00, 8'd4, 2, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 8'h00, 8'd4, 1, 8'h00, 8'h00, 8'h01});
    tbl.push_back('{8'h01, 8'h00, 8'd4, 3, 8'h01, 8'h01, 8'h00});
    tbl.push_back('{8'h03, 8'hFF, 8'd4, 3, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 8'hFF, 8'd4, 8, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{8'h03, 8'hFF, 8'd4, 5, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{8'h03, 8'hFF, 8'd4, 1, 8'h03, 8'h02, 8'h00});
    tbl.push_back('{8'h03, 8'hFF, 8'd4, 1, 8'h03, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 8'hFF, 8'd4, 5, 8'h03, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 8'hFF, 8'd4, 1, 8'h01, 8'h00, 8'h02});

    bus.pad_in_i = '0;
    bus.filter_en_i = '0;
    bus.filter_len_i = '0;
    rst_n = 1'b0;

    // Reset: held 3 cycles, then two quiet edges before the zero pads propagate.
    for (int i = 0; i < 3; i++) begin
      cyc();
      obs("rst", RV, '0, '0);
    end
    rst_n = 1'b1;
    cyc(); obs("post_rst1", RV, '0, '0);
    cyc(); obs("post_rst2", RV, '0, '0);
    cyc(); obs("post_rst3", 8'h00, '0, RV);
    cycn(2);

    // Bypass: pad0 rises, level follows on the third edge for exactly one pulse.
    bus.pad_in_i = 8'h01;
    cyc(); obs("byp_e1", 8'h00, '0, '0);
    cyc(); obs("byp_e2", 8'h00, '0, '0);
    cyc(); obs("byp_e3", 8'h01, 8'h01, '0);
    cyc(); obs("byp_e4", 8'h01, '0, '0);

    // Table: bypass round trip, glitch reject and stable accept with len=4.
    foreach (tbl[i]) begin
      bus.pad_in_i = tbl[i].pad;
      bus.filter_en_i = tbl[i].en;
      bus.filter_len_i = tbl[i].len;
      cycn(tbl[i].ncyc);
      obs($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall);
    end

    // Length shortened mid-count commits on the next edge.
    bus.filter_len_i = 8'd10;
    bus.pad_in_i = 8'h05;
    cycn(7); obs("len10_hold", 8'h01, '0, '0);
    bus.filter_len_i = 8'd3;
    cyc(); obs("len3_commit", 8'h05, 8'h04, '0);
    bus.filter_len_i = 8'd10;
    bus.pad_in_i = 8'h01;
    cycn(4); obs("len10_fall_hold", 8'h05, '0, '0);
    bus.filter_len_i = 8'd0;
    cyc(); obs("len0_commit", 8'h01, '0, 8'h04);

    // Reset mid-count discards the pending rise and restarts the full latency.
    bus.filter_len_i = 8'd8;
    bus.pad_in_i = 8'h0D;
    cycn(7); obs("len8_hold", 8'h01, '0, '0);
    rst_n = 1'b0;
    cyc(); obs("mid_rst", RV, '0, '0);
    rst_n = 1'b1;
    cycn(9); obs("rst_relaunch_hold", RV, '0, '0);
    cyc(); obs("rst_relaunch_commit", 8'h0D, 8'h08, 8'hA0);
    cyc();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0)
        bus.pad_in_i[$urandom_range(NP - 1)] ^= 1'b1;
      if (i % 37 == 0) bus.filter_en_i = NP'($urandom);
      if (i % 23 == 0) bus.filter_len_i = CW'($urandom_range(5));
      rst_n = ($urandom_range(150) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cycn(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
